// File: rtl/dec_pkg.sv
// dec_pkg: shared types, defaults and one-hot helper for dec_onehot_scan.
package dec_pkg;
  localparam int DEC_N = 3;
  localparam int DEC_SCAN_DIV = 4;
  // onehot_f covers select widths up to DEC_MAX_N
  localparam int DEC_MAX_N = 8;
  localparam int DEC_MAX_M = 2 ** DEC_MAX_N;
  typedef enum logic {DEC_DIRECT = 1'b0, DEC_SCAN = 1'b1} dec_mode_e;
  function automatic logic [DEC_MAX_M-1:0] onehot_f(input logic [DEC_MAX_N-1:0] i);
    logic [DEC_MAX_M-1:0] r;
    r = '0;
    r[i] = 1'b1;
    return r;
  endfunction
endpackage

// File: rtl/dec_prescaler.sv
// dec_prescaler: SCAN_DIV divider; tick marks the terminal-count cycle while running.
module dec_prescaler #(
  parameter int SCAN_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clr,
  output logic tick
);
  localparam int PW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  logic [PW-1:0] cnt;
  assign tick = run & ~clr & (cnt == PW'(SCAN_DIV - 1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (run) cnt <= tick ? '0 : cnt + PW'(1);
endmodule

// File: rtl/dec_onehot_scan.sv
// dec_onehot_scan: registered N-to-2^N one-hot decoder with direct and auto-scan modes.
// Define DEC_SKIP_MASK_EN to add skip_mask, letting the scan skip masked lines.
module dec_onehot_scan
  import dec_pkg::*;
#(
  parameter int N = DEC_N,
  parameter int SCAN_DIV = DEC_SCAN_DIV,
  localparam int M = 2 ** N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         mode,
  input  logic [N-1:0] w,
`ifdef DEC_SKIP_MASK_EN
  input  logic [M-1:0] skip_mask,
`endif
  output logic [M-1:0] y,
  output logic [N-1:0] idx,
  output logic         wrap
);
  dec_mode_e mode_q;
  logic scan, entry, tick, adv, any;
  logic [N-1:0] nxt, idx_d;
  logic [M-1:0] y_d;
  assign scan = dec_mode_e'(mode) == DEC_SCAN;
  assign entry = scan & (mode_q == DEC_DIRECT);
  dec_prescaler #(.SCAN_DIV(SCAN_DIV)) u_pre (
    .clk  (clk),
    .rst_n(rst_n),
    .run  (en & scan),
    .clr  (~scan | entry),
    .tick (tick)
  );
`ifdef DEC_SKIP_MASK_EN
  // any stays low only when every line is masked; k == M lands back on idx
  always_comb begin
    nxt = idx;
    any = 1'b0;
    for (int k = 1; k <= M; k++)
      if (!any && !skip_mask[idx + N'(k)]) begin
        nxt = idx + N'(k);
        any = 1'b1;
      end
  end
`else
  assign nxt = idx + N'(1);
  assign any = 1'b1;
`endif
  assign adv = tick & any;
  always_comb begin
    idx_d = !scan ? (en ? w : idx) : (adv ? nxt : idx);
    y_d = (en & (!scan | any)) ? M'(onehot_f(DEC_MAX_N'(idx_d))) : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      y <= '0;
      idx <= '0;
      wrap <= 1'b0;
      mode_q <= DEC_DIRECT;
    end else begin
      y <= y_d;
      idx <= idx_d;
      wrap <= adv & (nxt <= idx);
      mode_q <= dec_mode_e'(mode);
    end
endmodule
